// File: rtl/multi_pushbutton_processor.sv
// N-channel pushbutton front end: synchronise, debounce and classify presses as short (count_up) or long (count_down).
// Define MPB_AUTOREPEAT_EN to repeat count_down every REPEAT_MS cycles while a long press is held.
module multi_pushbutton_processor #(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 2000,
  parameter int REPEAT_MS   = 250,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic               clk_1khz,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] pushbutton_i,
  output logic [NUM_BTN-1:0] count_up,
  output logic [NUM_BTN-1:0] count_down,
  output logic [NUM_BTN-1:0] pressed_o
);

  localparam int DB_W   = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HOLD_W = $clog2(LONG_MS + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_MS);
`ifdef MPB_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
`endif

  if (NUM_BTN < 1 || DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_bad_param
    $error("multi_pushbutton_processor: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LONG = 2'd2} state_t;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] r_sync_p0;
  logic [NUM_BTN-1:0] r_sync_p1;

  assign w_raw = (ACTIVE_LOW != 0) ? ~pushbutton_i : pushbutton_i;

  // Stage p0/p1: two-flop synchroniser on the polarity-corrected inputs
  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_ch
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_deb;
    logic              w_toggle;
    logic              w_rise;
    logic              w_fall;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_up;
    logic              r_down;
    logic              w_up_nxt;
    logic              w_down_nxt;
`ifdef MPB_AUTOREPEAT_EN
    logic [REP_W-1:0]  r_rep_cnt;
    logic [REP_W-1:0]  w_rep_nxt;
`endif

    // The FSM sees the debounced edge in the same cycle the level register flips
    assign w_toggle = (r_sync_p1[k] != r_deb) && (r_db_cnt == DB_LAST);
    assign w_rise   = w_toggle & ~r_deb;
    assign w_fall   = w_toggle &  r_deb;

    // Debounce stage: accept a level change only after DEBOUNCE_MS consecutive differing samples
    always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
        r_db_cnt <= '0;
        r_deb    <= 1'b0;
      end else if (r_sync_p1[k] == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_deb    <= ~r_deb;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
        r_up       <= 1'b0;
        r_down     <= 1'b0;
`ifdef MPB_AUTOREPEAT_EN
        r_rep_cnt  <= '0;
`endif
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_nxt;
        r_up       <= w_up_nxt;
        r_down     <= w_down_nxt;
`ifdef MPB_AUTOREPEAT_EN
        r_rep_cnt  <= w_rep_nxt;
`endif
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_up_nxt    = 1'b0;
      w_down_nxt  = 1'b0;
`ifdef MPB_AUTOREPEAT_EN
      w_rep_nxt   = r_rep_cnt;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_HELD;
            w_hold_nxt  = HOLD_W'(1);
          end
        end
        S_HELD: begin
          if (r_hold_cnt < HOLD_LONG) w_hold_nxt = r_hold_cnt + 1'b1;
          // Reaching the long threshold wins over a release landing on the same edge
          if (r_hold_cnt == HOLD_LONG) begin
            w_down_nxt  = 1'b1;
            w_state_nxt = w_fall ? S_IDLE : S_LONG;
`ifdef MPB_AUTOREPEAT_EN
            w_rep_nxt   = '0;
`endif
          end else if (w_fall) begin
            w_up_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_LONG: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
`ifdef MPB_AUTOREPEAT_EN
            w_rep_nxt   = '0;
          end else if (r_rep_cnt == REP_LAST) begin
            w_down_nxt  = 1'b1;
            w_rep_nxt   = '0;
          end else begin
            w_rep_nxt   = r_rep_cnt + 1'b1;
`endif
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    assign count_up[k]   = r_up;
    assign count_down[k] = r_down;
    assign pressed_o[k]  = r_deb;
  end

endmodule
